// File: rtl/gb_oam_dma.sv
// gb_oam_dma: Game Boy OAM DMA controller.
// A write to FF46 copies 160 bytes from page {value,8'h00} into OAM, one byte
// every CYCLES_PER_BYTE clocks. Source pages at or above 0xE0 are folded down
// by 0x20 so that echo RAM reads the underlying work RAM.
module gb_oam_dma #(
    parameter int CYCLES_PER_BYTE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_write,
    input  logic [7:0]  reg_din,
    output logic [7:0]  reg_dout,
    output logic        active,
    output logic [15:0] adr_rd,
    output logic        read,
    input  logic [7:0]  din,
    output logic [7:0]  adr_wr,
    output logic        write,
    output logic [7:0]  dout
);

    localparam int PH_W = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(CYCLES_PER_BYTE - 1);
    localparam logic [PH_W-1:0] PH_LATCH = PH_W'(CYCLES_PER_BYTE - 2);
    localparam logic [PH_W-1:0] PH_ONE   = PH_W'(1);
    localparam logic [7:0]      IDX_LAST = 8'd159;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_src;
    logic [PH_W-1:0] r_ph;
    logic [7:0]      r_idx;
    logic [7:0]      r_latch;
    logic            r_hold;      // value of active carried through START
    logic            w_ph_last;
    logic            w_idx_last;
    logic [7:0]      w_page;

    assign w_ph_last  = (r_ph == PH_LAST);
    assign w_idx_last = (r_idx == IDX_LAST);
    assign w_page     = (r_src >= 8'hE0) ? (r_src - 8'h20) : r_src;
    assign reg_dout   = r_src;

    // State register; reset forces IDLE even against a simultaneous write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: a register write restarts from any state.
    always_comb begin
        w_next = r_state;
        if (reg_write) begin
            w_next = START;
        end else begin
            case (r_state)
                START:   if (w_ph_last) w_next = XFER;
                XFER:    if (w_ph_last && w_idx_last) w_next = IDLE;
                default: w_next = r_state;
            endcase
        end
    end

    // Page register, phase/index counters and the active-hold flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_src  <= 8'hFF;
            r_ph   <= '0;
            r_idx  <= 8'd0;
            r_hold <= 1'b0;
        end else if (reg_write) begin
            r_src  <= reg_din;
            r_ph   <= '0;
            r_idx  <= 8'd0;
            // Keep OAM blocked if a transfer was already owning it.
            r_hold <= (r_state == XFER) || ((r_state == START) && r_hold);
        end else begin
            case (r_state)
                START: begin
                    r_ph <= w_ph_last ? '0 : (r_ph + PH_ONE);
                end
                XFER: begin
                    if (w_ph_last) begin
                        r_ph <= '0;
                        if (!w_idx_last) begin
                            r_idx <= r_idx + 8'd1;
                        end
                    end else begin
                        r_ph <= r_ph + PH_ONE;
                    end
                end
                default: begin
                    r_ph <= '0;
                end
            endcase
        end
    end

    // Capture the source byte on the edge leaving the last read phase.
    always_ff @(posedge clk) begin
        if ((r_state == XFER) && (r_ph == PH_LATCH)) begin
            r_latch <= din;
        end
    end

    // Outputs: reads on phases 0..N-2, the OAM write on phase N-1.
    always_comb begin
        active = 1'b0;
        read   = 1'b0;
        write  = 1'b0;
        adr_rd = 16'h0000;
        adr_wr = 8'h00;
        dout   = 8'h00;
        case (r_state)
            START: begin
                active = r_hold;
                adr_rd = {w_page, r_idx};
                adr_wr = r_idx;
                dout   = r_latch;
            end
            XFER: begin
                active = 1'b1;
                adr_rd = {w_page, r_idx};
                adr_wr = r_idx;
                dout   = r_latch;
                read   = !w_ph_last;
                write  = w_ph_last;
            end
            default: begin
                active = 1'b0;
            end
        endcase
    end

endmodule
